// File: rtl/fa3_seq_adder.sv
// Digit-serial add/subtract controller: one 3-bit fa_3 slice is reused for
// SLICES cycles, least-significant digit first, with the carry kept in a register.

module fa_3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);
  logic [3:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 3; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[3];
endmodule

module fa3_seq_adder #(
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [3*SLICES-1:0]   op_a,
  input  logic [3*SLICES-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [3*SLICES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);
  localparam int W  = 3 * SLICES;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Captured operands, viewed digit-wise so the slice mux is a plain index.
  typedef struct packed {
    logic [SLICES-1:0][2:0] a;
    logic [SLICES-1:0][2:0] b;
  } opnd_t;

  state_t                 state;
  opnd_t                  opq;
  logic                   carry;
  logic [IW-1:0]          idx;
  logic [SLICES-1:0][2:0] acc;
  logic [SLICES-1:0][2:0] acc_nxt;

  logic [2:0] da, db, fs;
  logic       fc;
  logic       last;
  logic       c_msb;

  assign da   = opq.a[idx];
  assign db   = opq.b[idx];
  assign last = (idx == IW'(SLICES - 1));

  fa_3 u_fa (
    .a    (da),
    .b    (db),
    .cin  (carry),
    .s    (fs),
    .cout (fc)
  );

  // Carry into the top bit recovered from the slice's own sum bit.
  assign c_msb = da[2] ^ db[2] ^ fs[2];

  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = fs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opq   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opq.a <= op_a;
            opq.b <= sub ? ~op_b : op_b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= fc;
          if (last) begin
            sum   <= W'(acc_nxt);
            cout  <= fc;
            ovf   <= c_msb ^ fc;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fa3_seq_adder.sv
// Directed-vector bench for fa3_seq_adder (SLICES=4, 12-bit operands).

module tb_fa3_seq_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, cin;
  logic [11:0] op_a, op_b;
  logic        busy, done, cout, ovf;
  logic [11:0] sum;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fa3_seq_adder #(.SLICES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    string       name;
    logic        sub;
    logic        cin;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Accept one operation, then check latency, busy length, sum hold and result.
  task automatic run_op(input string nm, input logic s, input logic c,
                        input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] esum, input logic ecout, input logic eovf);
    int lat;
    int nbusy;
    logic held;
    logic [11:0] prev;
    @(negedge clk);
    prev  = sum;
    start = 1'b1; sub = s; cin = c; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; sub = ~s; cin = ~c; op_a = ~a; op_b = 12'h5a5;
    lat = 1; nbusy = 0; held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (sum !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy) nbusy++;
    chk({nm, " latency"}, lat, 5);
    chk({nm, " busy_cycles"}, nbusy, 5);
    chk({nm, " sum_held"}, held, 1);
    chk({nm, " sum"}, sum, esum);
    chk({nm, " cout"}, cout, ecout);
    chk({nm, " ovf"}, ovf, eovf);
    @(negedge clk);
    chk({nm, " done_pulse"}, {busy, done}, 0);
  endtask

  initial begin
    int ndone;
    vecs[0] = '{"add_wrap",   1'b0, 1'b0, 12'hfff, 12'h001, 12'h000, 1'b1, 1'b0};
    vecs[1] = '{"add_cin",    1'b0, 1'b1, 12'h5a5, 12'h3c3, 12'h969, 1'b0, 1'b1};
    vecs[2] = '{"sub_pos",    1'b1, 1'b1, 12'h100, 12'h001, 12'h0ff, 1'b1, 1'b0};
    vecs[3] = '{"sub_borrow", 1'b1, 1'b0, 12'h001, 12'h002, 12'hfff, 1'b0, 1'b0};
    vecs[4] = '{"ovf_pos",    1'b0, 1'b0, 12'h7ff, 12'h001, 12'h800, 1'b0, 1'b1};
    vecs[5] = '{"ovf_neg",    1'b0, 1'b0, 12'h800, 12'h800, 12'h000, 1'b1, 1'b1};
    vecs[6] = '{"sub_ovf",    1'b1, 1'b0, 12'h800, 12'h001, 12'h7ff, 1'b1, 1'b1};
    vecs[7] = '{"add_plain",  1'b0, 1'b0, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, cout, ovf, sum}, 0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // Busy lockout: start pulses during RUN and DONE must be ignored.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; cin = 1'b0; op_a = 12'h123; op_b = 12'h111;
    @(negedge clk);
    start = 1'b0; op_a = 12'hfff; op_b = 12'hfff;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      start = (k == 1) || done;
      sub   = (k == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("lockout_done_count", ndone, 1);
    chk("lockout_sum", sum, 12'h234);
    chk("lockout_idle", busy, 0);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk);
    start = 1'b1; op_a = 12'h00a; op_b = 12'h00b; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrun_reset", {busy, done, cout, ovf, sum}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrun_no_done", ndone, 0);
    run_op("after_reset", 1'b0, 1'b0, 12'h00a, 12'h005, 12'h00f, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
